// File: rtl/seq_scheduler_if.sv
// Control and note bus between the two-track sequencer and its host.
// The host drives keys, strobes and requests; the sequencer returns notes and status.
interface seq_scheduler_if #(
    parameter int NOTE_W = 9
);
    logic              clear;
    logic [NOTE_W-1:0] note_in;
    logic              note_strobe;
    logic [1:0]        rec_sel;
    logic [1:0]        play_req;
    logic              step_tick;
    logic [NOTE_W-1:0] note_out;
    logic              note_valid;
    logic [1:0]        state_o;
    logic              active_track;
    logic [3:0]        count0;
    logic [3:0]        count1;

    modport master (
        output clear, note_in, note_strobe, rec_sel, play_req, step_tick,
        input  note_out, note_valid, state_o, active_track, count0, count1
    );

    modport slave (
        input  clear, note_in, note_strobe, rec_sel, play_req, step_tick,
        output note_out, note_valid, state_o, active_track, count0, count1
    );
endinterface

// File: rtl/seq_scheduler.sv
// Two-track note sequencer: records one-hot key presses per track and plays
// them back on step ticks, sharing one output with round-robin playback grants.
module seq_scheduler #(
    parameter int DEPTH  = 9,
    parameter int NOTE_W = 9
) (
    input logic            clk,
    input logic            reset,
    seq_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RECORD = 2'b01,
        PLAY   = 2'b10
    } state_t;

    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    state_t            state;
    logic [NOTE_W-1:0] note_out_r;
    logic              note_valid_r;
    logic              active;
    logic              rr_pref;
    logic [3:0]        cnt0;
    logic [3:0]        cnt1;
    logic [3:0]        idx;

    logic [NOTE_W-1:0] mem0 [DEPTH];
    logic [NOTE_W-1:0] mem1 [DEPTH];

    logic [3:0]        cur_cnt;
    logic              one_hot;
    logic              accept;
    logic [1:0]        rec_code;
    logic              elig0;
    logic              elig1;
    logic              grant;
    logic              grant_trk;
    logic [NOTE_W-1:0] rd_note;

    always_comb begin
        cur_cnt   = active ? cnt1 : cnt0;
        one_hot   = (bus.note_in != '0) &&
                    ((bus.note_in & (bus.note_in - NOTE_W'(1))) == '0);
        accept    = (state == RECORD) && bus.note_strobe && one_hot &&
                    (cur_cnt < DEPTH_C);
        rec_code  = active ? 2'b10 : 2'b01;
        elig0     = bus.play_req[0] && (cnt0 != '0);
        elig1     = bus.play_req[1] && (cnt1 != '0);
        grant     = elig0 || elig1;
        // rr_pref names the track that wins when both tracks are eligible
        grant_trk = (elig0 && elig1) ? rr_pref : elig1;
        rd_note   = active ? mem1[idx] : mem0[idx];
    end

    // Storage is never reset; the counts alone decide what is readable.
    always_ff @(posedge clk) begin
        if (!reset && !bus.clear && accept) begin
            if (active) mem1[cur_cnt] <= bus.note_in;
            else        mem0[cur_cnt] <= bus.note_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt0         <= '0;
            cnt1         <= '0;
            idx          <= '0;
            note_out_r   <= '0;
            note_valid_r <= 1'b0;
            active       <= 1'b0;
            rr_pref      <= 1'b0;
        end else if (bus.clear) begin
            state        <= IDLE;
            cnt0         <= '0;
            cnt1         <= '0;
            note_out_r   <= '0;
            note_valid_r <= 1'b0;
        end else begin
            note_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.rec_sel == 2'b01 || bus.rec_sel == 2'b10) begin
                        state  <= RECORD;
                        active <= bus.rec_sel[1];
                        if (bus.rec_sel[1]) cnt1 <= '0;
                        else                cnt0 <= '0;
                    end else if (grant) begin
                        state   <= PLAY;
                        active  <= grant_trk;
                        idx     <= '0;
                        rr_pref <= ~grant_trk;
                    end
                end
                RECORD: begin
                    if (accept) begin
                        note_out_r <= bus.note_in;
                        if (active) cnt1 <= cnt1 + 4'd1;
                        else        cnt0 <= cnt0 + 4'd1;
                    end
                    if (bus.rec_sel != rec_code) state <= IDLE;
                end
                PLAY: begin
                    if (bus.step_tick) begin
                        note_out_r   <= rd_note;
                        note_valid_r <= 1'b1;
                        if (idx == cur_cnt - 4'd1) state <= IDLE;
                        else                       idx   <= idx + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.note_out     = note_out_r;
    assign bus.note_valid   = note_valid_r;
    assign bus.state_o      = state;
    assign bus.active_track = active;
    assign bus.count0       = cnt0;
    assign bus.count1       = cnt1;
endmodule
